// File: rtl/axis_test_pkg.sv
// Shared constants and FSM encoding for the AXI-Stream test sink.
package axis_test_pkg;

    localparam int DATA_W = 256;
    localparam int WORD_W = 16;
    localparam int NLANE  = DATA_W / WORD_W;

    localparam logic [31:0] KEEP_FULL = 32'hFFFF_FFFF;
    localparam logic [31:0] KEEP_LAST = 32'h0000_0003;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } state_e;

endpackage

// File: rtl/axi_stream_checker_if.sv
// AXI-Stream bundle between the test source (master) and the checker sink (slave).
interface axi_stream_checker_if #(
    parameter int DATA_W = 256
) ();

    logic [DATA_W-1:0]   tdata;
    logic                tvalid;
    logic                tlast;
    logic [DATA_W/8-1:0] tkeep;
    logic                tready;

    modport master (
        output tdata, tvalid, tlast, tkeep,
        input  tready
    );

    modport slave (
        input  tdata, tvalid, tlast, tkeep,
        output tready
    );

endinterface

// File: rtl/axis_ready_lfsr.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11) providing the tready throttle bit.
module axis_ready_lfsr #(
    parameter logic [15:0] SEED = 16'hACE1
) (
    input  logic clk,
    input  logic resentn,
    input  logic enable_i,
    output logic bit_o
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        feedback;

    always_comb begin
        feedback = lfsr_q[0] ^ lfsr_q[2] ^ lfsr_q[3] ^ lfsr_q[5];
        lfsr_d   = enable_i ? {feedback, lfsr_q[15:1]} : lfsr_q;
    end

    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            lfsr_q <= SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign bit_o = lfsr_q[0];

endmodule

// File: rtl/axi_stream_checker.sv
// AXI-Stream sink checking a replicated counter payload, tkeep pattern and tlast framing,
// with packet/error counters and optional pseudo-random tready throttling.
module axi_stream_checker
    import axis_test_pkg::*;
#(
    parameter int          DATA_W    = 256,
    parameter int          WORD_W    = 16,
    parameter int          CNT_W     = 16,
    parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
    input  logic                  clk,
    input  logic                  resentn,
    input  logic                  enable_i,
    input  logic                  throttle_i,
    input  logic [3:0]            beats_per_packet_i,
    input  logic                  err_clear_i,
    axi_stream_checker_if.slave   axis_s,
    output logic [3:0]            beat_o,
    output logic [CNT_W-1:0]      pkt_count_o,
    output logic                  err_data_o,
    output logic                  err_keep_o,
    output logic                  err_last_o,
    output logic [CNT_W-1:0]      err_count_o
);

    localparam int LANES  = DATA_W / WORD_W;
    localparam int KEEP_W = DATA_W / 8;
    localparam int KPL    = WORD_W / 8;
    localparam logic [KEEP_W-1:0] KEEP_LAST_P = KEEP_W'(KEEP_LAST);

    state_e             state_q, state_d;
    logic               tready_q, tready_d;
    logic [3:0]         beat_q, beat_d;
    logic [3:0]         bpp_lat_q, bpp_lat_d;
    logic [WORD_W-1:0]  exp_val_q, exp_val_d;
    logic [CNT_W-1:0]   pkt_count_q, pkt_count_d;
    logic               err_data_q, err_data_d;
    logic               err_keep_q, err_keep_d;
    logic               err_last_q, err_last_d;
    logic [CNT_W-1:0]   err_count_q, err_count_d;

    logic               accept;
    logic               lfsr_bit;
    logic [3:0]         bpp_cur;
    logic               is_last;
    logic               data_err;
    logic               keep_err;
    logic               last_err;
    logic [CNT_W-1:0]   cnt_base;

    axis_ready_lfsr #(
        .SEED (LFSR_SEED)
    ) u_lfsr (
        .clk      (clk),
        .resentn  (resentn),
        .enable_i (state_q == RUN),
        .bit_o    (lfsr_bit)
    );

    // At packet start the live length input is used so a one-beat packet is framed correctly.
    always_comb begin
        accept   = axis_s.tvalid & tready_q;
        bpp_cur  = (beat_q == 4'd0) ? beats_per_packet_i : bpp_lat_q;
        is_last  = (beat_q == bpp_cur);
        keep_err = (axis_s.tkeep != (is_last ? KEEP_LAST_P : {KEEP_W{1'b1}}));
        last_err = (axis_s.tlast != is_last);
        data_err = 1'b0;
        for (int l = 0; l < LANES; l++) begin
            if ((&axis_s.tkeep[l*KPL +: KPL]) &&
                (axis_s.tdata[l*WORD_W +: WORD_W] != exp_val_q)) begin
                data_err = 1'b1;
            end
        end
    end

    always_comb begin
        beat_d      = beat_q;
        bpp_lat_d   = bpp_lat_q;
        exp_val_d   = exp_val_q;
        pkt_count_d = pkt_count_q;
        if (accept) begin
            exp_val_d = axis_s.tdata[WORD_W-1:0] + WORD_W'(1);
            if (beat_q == 4'd0) begin
                bpp_lat_d = beats_per_packet_i;
            end
            if (axis_s.tlast) begin
                pkt_count_d = pkt_count_q + CNT_W'(1);
            end
            beat_d = (axis_s.tlast || is_last) ? 4'd0 : beat_q + 4'd1;
        end

        state_d = state_q;
        case (state_q)
            IDLE:    if (enable_i) state_d = RUN;
            RUN:     if (!enable_i && beat_d == 4'd0) state_d = IDLE;
            default: state_d = IDLE;
        endcase
        tready_d = (state_d == RUN) & (~throttle_i | lfsr_bit);
    end

    // A clear in the same cycle as a new error leaves only the new error recorded.
    always_comb begin
        err_data_d  = (err_clear_i ? 1'b0 : err_data_q) | (accept & data_err);
        err_keep_d  = (err_clear_i ? 1'b0 : err_keep_q) | (accept & keep_err);
        err_last_d  = (err_clear_i ? 1'b0 : err_last_q) | (accept & last_err);
        cnt_base    = err_clear_i ? '0 : err_count_q;
        err_count_d = cnt_base;
        if (accept && (data_err || keep_err || last_err) && !(&cnt_base)) begin
            err_count_d = cnt_base + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge resentn) begin
        if (!resentn) begin
            state_q     <= IDLE;
            tready_q    <= 1'b0;
            beat_q      <= 4'd0;
            bpp_lat_q   <= 4'd0;
            exp_val_q   <= '0;
            pkt_count_q <= '0;
            err_data_q  <= 1'b0;
            err_keep_q  <= 1'b0;
            err_last_q  <= 1'b0;
            err_count_q <= '0;
        end else begin
            state_q     <= state_d;
            tready_q    <= tready_d;
            beat_q      <= beat_d;
            bpp_lat_q   <= bpp_lat_d;
            exp_val_q   <= exp_val_d;
            pkt_count_q <= pkt_count_d;
            err_data_q  <= err_data_d;
            err_keep_q  <= err_keep_d;
            err_last_q  <= err_last_d;
            err_count_q <= err_count_d;
        end
    end

    assign axis_s.tready = tready_q;
    assign beat_o        = beat_q;
    assign pkt_count_o   = pkt_count_q;
    assign err_data_o    = err_data_q;
    assign err_keep_o    = err_keep_q;
    assign err_last_o    = err_last_q;
    assign err_count_o   = err_count_q;

endmodule

// File: tb/tb_axi_stream_checker.sv
// Scoreboard bench for axi_stream_checker: randomized source, reference model queue, monitor.
module tb_axi_stream_checker;
    import axis_test_pkg::*;

    localparam int DW    = 256;
    localparam int KW    = DW / 8;
    localparam int LANES = DW / 16;

    logic        clk = 1'b0;
    logic        resentn;
    logic        enable;
    logic        throttle;
    logic [3:0]  bpp;
    logic        errClear;
    logic [3:0]  beatOut;
    logic [15:0] pktCount;
    logic        errData, errKeep, errLast;
    logic [15:0] errCount;

    axi_stream_checker_if #(.DATA_W(DW)) axis ();

    axi_stream_checker dut (
        .clk                (clk),
        .resentn            (resentn),
        .enable_i           (enable),
        .throttle_i         (throttle),
        .beats_per_packet_i (bpp),
        .err_clear_i        (errClear),
        .axis_s             (axis),
        .beat_o             (beatOut),
        .pkt_count_o        (pktCount),
        .err_data_o         (errData),
        .err_keep_o         (errKeep),
        .err_last_o         (errLast),
        .err_count_o        (errCount)
    );

    always #5 clk = ~clk;

    typedef struct {
        int beat;
        int pkt;
        bit eD;
        bit eK;
        bit eL;
        int cnt;
    } snap_t;

    snap_t       expQ[$];
    int          checks = 0;
    int          errors = 0;
    int          stallCount = 0;
    logic [15:0] srcVal;
    bit          scrambleBpp = 0;
    bit          corruptEn = 0;

    // Reference model: packet position, latched length, next expected word, sticky results.
    int          mBeat, mLen, mPkt, mErrCnt;
    bit          mED, mEK, mEL;
    logic [15:0] mExp;

    function automatic void modelReset();
        mBeat = 0; mLen = 0; mPkt = 0; mErrCnt = 0;
        mED = 0; mEK = 0; mEL = 0; mExp = 16'h0000;
        expQ.delete();
    endfunction

    function automatic void modelBeat(input logic [DW-1:0] d, input logic [KW-1:0] keep,
                                      input logic last, input bit clr);
        bit    isLast, dE, kE, lE;
        snap_t s;
        if (mBeat == 0) mLen = int'(bpp);
        isLast = (mBeat == mLen);
        dE = 0;
        for (int l = 0; l < LANES; l++) begin
            if (keep[2*l +: 2] == 2'b11 && d[16*l +: 16] != mExp) dE = 1;
        end
        kE = (keep != (isLast ? KEEP_LAST : KEEP_FULL));
        lE = (last != isLast);
        if (clr) begin
            mED = 0; mEK = 0; mEL = 0; mErrCnt = 0;
        end
        mED = mED | dE;
        mEK = mEK | kE;
        mEL = mEL | lE;
        if ((dE || kE || lE) && mErrCnt < 65535) mErrCnt++;
        if (last) mPkt = (mPkt + 1) % 65536;
        mBeat = (last || isLast) ? 0 : mBeat + 1;
        mExp = d[15:0] + 16'd1;
        s.beat = mBeat; s.pkt = mPkt; s.eD = mED; s.eK = mEK; s.eL = mEL; s.cnt = mErrCnt;
        expQ.push_back(s);
    endfunction

    task automatic checkOutput(input string name, input longint actual, input longint expected);
        checks++;
        if (actual != expected) begin
            errors++;
            $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
        end
    endtask

    // Drives one beat and holds it until tready is seen; the model runs just before the accepting edge.
    task automatic applyStimulus(input logic [15:0] val, input logic [KW-1:0] keep, input logic last,
                                 input int badLane, input logic [15:0] badVal, input bit clr);
        logic [DW-1:0] d;
        int            guard;
        bit            done;
        for (int l = 0; l < LANES; l++) begin
            if (keep[2*l +: 2] == 2'b11) d[16*l +: 16] = (l == badLane) ? badVal : val;
            else                         d[16*l +: 16] = 16'($urandom);
        end
        repeat ($urandom_range(0, 1)) @(negedge clk);
        axis.tdata  = d;
        axis.tkeep  = keep;
        axis.tlast  = last;
        axis.tvalid = 1'b1;
        guard = 0;
        done  = 0;
        while (!done) begin
            if (axis.tready) begin
                errClear = clr;
                modelBeat(d, keep, last, clr);
                done = 1;
            end else begin
                stallCount++;
                guard++;
                if (guard > 200) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL handshake timeout: tready low for %0d cycles, required high", guard);
                    done = 1;
                end
            end
            @(negedge clk);
            errClear = 1'b0;
        end
        axis.tvalid = 1'b0;
    endtask

    task automatic sendPacket(input int lastIdx);
        int badLane;
        bpp = 4'(lastIdx);
        for (int b = 0; b <= lastIdx; b++) begin
            badLane = (corruptEn && $urandom_range(0, 7) == 0) ? int'($urandom_range(1, 15)) : -1;
            applyStimulus(srcVal, (b == lastIdx) ? KEEP_LAST : KEEP_FULL, b == lastIdx,
                          badLane, srcVal ^ 16'h00F0, 0);
            srcVal++;
            if (scrambleBpp && b != lastIdx) bpp = 4'($urandom);
        end
    endtask

    task automatic applyReset();
        @(negedge clk);
        resentn = 1'b0;
        modelReset();
        #1;
        checkOutput("reset tready", axis.tready, 0);
        checkOutput("reset beat", beatOut, 0);
        checkOutput("reset pkt_count", pktCount, 0);
        checkOutput("reset err flags", {errData, errKeep, errLast}, 0);
        checkOutput("reset err_count", errCount, 0);
        repeat (2) @(negedge clk);
        resentn = 1'b1;
        enable  = 1'b1;
        repeat (2) @(negedge clk);
        stallCount = 0;
    endtask

    // Monitor: every handshake is followed one edge later by the registered counters.
    initial begin
        bit    hs;
        snap_t e;
        forever begin
            @(negedge clk);
            #2;
            hs = axis.tvalid && axis.tready && resentn;
            @(posedge clk);
            #1;
            if (hs) begin
                if (expQ.size() == 0) begin
                    checks++;
                    errors++;
                    $display("[TB] FAIL scoreboard: accept seen, expected queue empty");
                end else begin
                    e = expQ.pop_front();
                    checkOutput("sb beat", beatOut, e.beat);
                    checkOutput("sb pkt_count", pktCount, e.pkt);
                    checkOutput("sb err_data", errData, e.eD);
                    checkOutput("sb err_keep", errKeep, e.eK);
                    checkOutput("sb err_last", errLast, e.eL);
                    checkOutput("sb err_count", errCount, e.cnt);
                end
            end
        end
    end

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        resentn = 1'b0; enable = 1'b0; throttle = 1'b0; bpp = 4'd0; errClear = 1'b0;
        axis.tvalid = 1'b0; axis.tlast = 1'b0; axis.tkeep = '0; axis.tdata = '0;
        modelReset();
        #12;
        resentn = 1'b1;

        $display("[TB] test 1: three clean packets, no throttle");
        applyReset();
        srcVal = 16'h0000;
        repeat (3) sendPacket(3);
        checkOutput("t1 pkt_count", pktCount, 3);
        checkOutput("t1 beat", beatOut, 0);
        checkOutput("t1 err_count", errCount, 0);
        checkOutput("t1 stalls", stallCount, 0);

        $display("[TB] test 2: 200 throttled beats, bpp=2");
        applyReset();
        throttle = 1'b1;
        bpp = 4'd2;
        srcVal = 16'h0000;
        for (int i = 0; i < 200; i++) begin
            applyStimulus(srcVal, (i % 3 == 2) ? KEEP_LAST : KEEP_FULL, i % 3 == 2, -1, 16'h0, 0);
            srcVal++;
        end
        checkOutput("t2 pkt_count", pktCount, 66);
        checkOutput("t2 beat", beatOut, 2);
        checkOutput("t2 err_count", errCount, 0);
        checkOutput("t2 tready throttled", stallCount > 0, 1);
        throttle = 1'b0;

        $display("[TB] test 3: corrupt lane 7 of beat 5");
        applyReset();
        bpp = 4'd3;
        srcVal = 16'h0000;
        for (int b = 0; b < 12; b++) begin
            applyStimulus(srcVal, (b % 4 == 3) ? KEEP_LAST : KEEP_FULL, b % 4 == 3,
                          (b == 5) ? 7 : -1, 16'h1234, 0);
            srcVal++;
        end
        checkOutput("t3 err_data", errData, 1);
        checkOutput("t3 err_count", errCount, 1);
        checkOutput("t3 other flags", {errKeep, errLast}, 0);
        checkOutput("t3 pkt_count", pktCount, 3);

        $display("[TB] test 4: early tlast on beat 1");
        applyReset();
        bpp = 4'd3;
        srcVal = 16'h0000;
        applyStimulus(16'h0000, KEEP_FULL, 1'b0, -1, 16'h0, 0);
        applyStimulus(16'h0001, KEEP_FULL, 1'b1, -1, 16'h0, 0);
        checkOutput("t4 beat after early last", beatOut, 0);
        srcVal = 16'h0002;
        sendPacket(3);
        checkOutput("t4 err_last", errLast, 1);
        checkOutput("t4 err_count", errCount, 1);
        checkOutput("t4 pkt_count", pktCount, 2);
        checkOutput("t4 other flags", {errData, errKeep}, 0);

        $display("[TB] test 5: bad last-beat tkeep, err_clear");
        applyReset();
        bpp = 4'd3;
        for (int b = 0; b < 4; b++) applyStimulus(16'(b), (b == 3) ? KEEP_FULL : KEEP_FULL, b == 3, -1, 16'h0, 0);
        checkOutput("t5 err_keep", errKeep, 1);
        checkOutput("t5 other flags", {errData, errLast}, 0);
        checkOutput("t5 err_count", errCount, 1);
        errClear = 1'b1;
        @(negedge clk);
        errClear = 1'b0;
        mED = 0; mEK = 0; mEL = 0; mErrCnt = 0;
        checkOutput("t5 flags cleared", {errData, errKeep, errLast}, 0);
        checkOutput("t5 count cleared", errCount, 0);
        for (int b = 4; b < 8; b++) applyStimulus(16'(b), KEEP_FULL, b == 7, -1, 16'h0, 0);
        applyStimulus(16'h0008, KEEP_FULL, 1'b0, 3, 16'hBEEF, 1);
        checkOutput("t5 clear+error keep", errKeep, 0);
        checkOutput("t5 clear+error data", errData, 1);
        checkOutput("t5 clear+error count", errCount, 1);

        $display("[TB] test 6: 16-bit wrap and mid-packet reset");
        applyReset();
        bpp = 4'd3;
        srcVal = 16'hFFFA;
        sendPacket(3);
        errClear = 1'b1;
        @(negedge clk);
        errClear = 1'b0;
        mED = 0; mEK = 0; mEL = 0; mErrCnt = 0;
        sendPacket(3);
        checkOutput("t6 wrap err_count", errCount, 0);
        checkOutput("t6 wrap flags", {errData, errKeep, errLast}, 0);
        checkOutput("t6 pkt_count", pktCount, 2);
        applyStimulus(srcVal, KEEP_FULL, 1'b0, -1, 16'h0, 0);
        srcVal++;
        applyStimulus(srcVal, KEEP_FULL, 1'b0, -1, 16'h0, 0);
        checkOutput("t6 mid-packet beat", beatOut, 2);
        #3;
        resentn = 1'b0;
        modelReset();
        #1;
        checkOutput("t6 async tready", axis.tready, 0);
        checkOutput("t6 async beat", beatOut, 0);
        checkOutput("t6 async pkt_count", pktCount, 0);
        checkOutput("t6 async err_count", errCount, 0);
        @(negedge clk);
        resentn = 1'b1;

        $display("[TB] test 7: random lengths, throttle, mid-packet length changes, corruption");
        applyReset();
        scrambleBpp = 1;
        corruptEn = 1;
        srcVal = 16'h0000;
        for (int p = 0; p < 25; p++) begin
            throttle = 1'($urandom_range(0, 1));
            sendPacket(int'($urandom_range(0, 15)));
        end
        checkOutput("t7 pkt_count", pktCount, 25);
        checkOutput("t7 model pkt_count", pktCount, mPkt);
        checkOutput("t7 err_count", errCount, mErrCnt);

        repeat (3) @(negedge clk);
        checkOutput("scoreboard drained", expQ.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
